// File: rtl/vga_rx_monitor.sv
// Receive-side VGA timing monitor: locks onto HSYNC/VSYNC, checks line/frame
// timing and emits a registered (x, y, colour) pixel stream once locked.
//
// state    | meaning
// S_SEARCH | waiting for the first HSYNC leading edge
// S_HCHK   | measuring one line length between HSYNC edges
// S_HLOCK  | line timing good, waiting for VSYNC aligned with HSYNC
// S_LOCKED | line and frame timing verified, pixels emitted
module vga_rx_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int SYNC_ACT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic [6:0] vga,
  output logic       locked,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [4:0] pix_data,
  output logic       frame_done,
  output logic       h_err,
  output logic       v_err,
  output logic [7:0] err_cnt
);

  localparam logic       SACT = 1'(SYNC_ACT);
  localparam logic [9:0] HT1  = 10'(H_TOTAL - 1);
  localparam logic [9:0] HSW  = 10'(H_SYNC);
  localparam logic [9:0] HA0  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HA1  = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] HXL  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] VT1  = 10'(V_TOTAL - 1);
  localparam logic [9:0] VSW  = 10'(V_SYNC);
  localparam logic [9:0] VA0  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VA1  = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] VYL  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] CMAX = 10'h3ff;

  typedef enum logic [1:0] {S_SEARCH, S_HCHK, S_HLOCK, S_LOCKED} state_t;

  state_t     state, state_nx;
  logic       hs_prev, vs_prev;
  logic [9:0] hcnt, vcnt;

  logic       hs, vs, hs_edge, vs_edge, hs_fall, vs_fall;
  logic [9:0] hcnt_nx, vcnt_nx;
  logic       chk_h, chk_v, herr_c, verr_c, any_err, pix_vis;
  logic       h_e, v_e;
  logic [8:0] err_sum;

  assign hs      = (vga[6] == SACT);
  assign vs      = (vga[5] == SACT);
  assign hs_edge = hs & ~hs_prev;
  assign vs_edge = vs & ~vs_prev;
  assign hs_fall = ~hs & hs_prev;
  assign vs_fall = ~vs & vs_prev;

  assign hcnt_nx = hs_edge ? 10'd0 : ((hcnt == CMAX) ? CMAX : hcnt + 10'd1);
  assign vcnt_nx = vs_edge ? 10'd0 : (hs_edge ? vcnt + 10'd1 : vcnt);

  assign chk_h = (state == S_HLOCK) || (state == S_LOCKED);
  assign chk_v = (state == S_LOCKED);

  assign herr_c = chk_h & ((hs_edge & (hcnt != HT1)) |
                           (hs_fall & (hcnt_nx != HSW)) |
                           ((hcnt_nx == CMAX) & (hcnt != CMAX)));
  assign verr_c = chk_v & ((vs_edge & (~hs_edge | (vcnt != VT1))) |
                           (vs_fall & hs_edge & (vcnt_nx != VSW)));
  assign any_err = herr_c | verr_c;

  // the sample that trips a check never yields a pixel
  assign pix_vis = (state == S_LOCKED) & ~any_err &
                   (hcnt_nx >= HA0) & (hcnt_nx < HA1) &
                   (vcnt_nx >= VA0) & (vcnt_nx < VA1);

  assign h_e     = pix_en & herr_c;
  assign v_e     = pix_en & verr_c;
  assign err_sum = {1'b0, err_cnt} + {8'd0, h_e} + {8'd0, v_e};
  assign locked  = (state == S_LOCKED);

  always_comb begin
    state_nx = state;
    if (pix_en) begin
      if (any_err) begin
        state_nx = S_SEARCH;
      end else begin
        case (state)
          S_SEARCH: if (hs_edge) state_nx = S_HCHK;
          S_HCHK:   if (hs_edge && hcnt == HT1) state_nx = S_HLOCK;
          S_HLOCK:  if (vs_edge && hs_edge) state_nx = S_LOCKED;
          default:  state_nx = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_SEARCH;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev    <= 1'b0;
      vs_prev    <= 1'b0;
      hcnt       <= 10'd0;
      vcnt       <= 10'd0;
      pix_valid  <= 1'b0;
      pix_x      <= 10'd0;
      pix_y      <= 10'd0;
      pix_data   <= 5'd0;
      frame_done <= 1'b0;
      h_err      <= 1'b0;
      v_err      <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      pix_valid  <= pix_en & pix_vis;
      frame_done <= pix_en & pix_vis & (hcnt_nx == HXL) & (vcnt_nx == VYL);
      h_err      <= h_e;
      v_err      <= v_e;
      err_cnt    <= err_sum[8] ? 8'hff : err_sum[7:0];
      if (pix_en) begin
        hs_prev <= hs;
        vs_prev <= vs;
        hcnt    <= hcnt_nx;
        vcnt    <= vcnt_nx;
        if (pix_vis) begin
          pix_x    <= hcnt_nx - HA0;
          pix_y    <= vcnt_nx - VA0;
          pix_data <= vga[4:0];
        end
      end
    end
  end

endmodule
